// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings and dependency helper for the hazard stall controller
package hazard_pkg;

   localparam logic [1:0] ST_RUN       = 2'd0;
   localparam logic [1:0] ST_BR_STALL2 = 2'd1;
   localparam logic [1:0] ST_MD_WAIT   = 2'd2;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // Pipeline control bundle, one bit per enable the controller drives
   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic ifid_flush;
      logic idex_write;
      logic idex_bubble;
      logic exmem_bubble;
      logic md_start;
   } ctrl_t;

   localparam ctrl_t CTRL_RUN   = 7'b1101000;
   localparam ctrl_t CTRL_STALL = 7'b0001100;
   localparam ctrl_t CTRL_MD    = 7'b0000010;
   localparam ctrl_t CTRL_RESET = 7'b0000110;

   // Register x is a live source of the ID instruction; r0 never creates a hazard
   function automatic logic dep(input logic [4:0] x, input logic [4:0] rs,
                                input logic [4:0] rt, input logic uses_rt);
      return (x != REG_ZERO) && ((x == rs) || (uses_rt && (x == rt)));
   endfunction

endpackage

// File: rtl/hazard_stall_controller_if.sv
// rtl/hazard_stall_controller_if.sv - pipeline hazard inputs and stall/flush control bundle
interface hazard_stall_controller_if #(parameter int CNT_W = 16);

   logic [4:0]       RS_ID;
   logic [4:0]       RT_ID;
   logic             UsesRt_ID;
   logic             Branch_ID;
   logic             BranchTaken_ID;
   logic [4:0]       RD_EX;
   logic             RegWrite_EX;
   logic             MemRead_EX;
   logic             MulDiv_EX;
   logic [4:0]       RD_MEM;
   logic             MemRead_MEM;
   logic             MulDiv_Done;
   logic             PCWrite;
   logic             IFID_Write;
   logic             IFID_Flush;
   logic             IDEX_Write;
   logic             IDEX_Bubble;
   logic             EXMEM_Bubble;
   logic             MulDiv_Start;
   logic             MulDiv_Err;
   logic [CNT_W-1:0] StallCount;

   // Pipeline side: reports stage contents, consumes the enables
   modport master (
      output RS_ID, RT_ID, UsesRt_ID, Branch_ID, BranchTaken_ID, RD_EX, RegWrite_EX,
             MemRead_EX, MulDiv_EX, RD_MEM, MemRead_MEM, MulDiv_Done,
      input  PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Bubble,
             MulDiv_Start, MulDiv_Err, StallCount
   );

   // Controller side
   modport slave (
      input  RS_ID, RT_ID, UsesRt_ID, Branch_ID, BranchTaken_ID, RD_EX, RegWrite_EX,
             MemRead_EX, MulDiv_EX, RD_MEM, MemRead_MEM, MulDiv_Done,
      output PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Bubble,
             MulDiv_Start, MulDiv_Err, StallCount
   );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-low clear
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             en,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Count up on enable, hold at all-ones instead of wrapping
   always_comb begin
      cnt_d = cnt_q;
      if (!clr_n) begin
         cnt_d = '0;
      end else if (en && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register
   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - load-use, branch-dependency and MUL/DIV stall sequencer
module hazard_stall_controller
   import hazard_pkg::*;
#(
   parameter int MD_TIMEOUT = 64,
   parameter int CNT_W      = 16
) (
   input logic                      Clk,
   input logic                      Reset,
   hazard_stall_controller_if.slave bus
);

   localparam int TW = $clog2(MD_TIMEOUT + 1);

   logic [1:0]    state_q, state_d;
   logic [TW-1:0] md_cnt_q, md_cnt_d;
   logic          err_q, err_d;
   logic          started_q, started_d;
   logic          lu, br1, br2, md_hit;
   ctrl_t         ctrl;
   logic [CNT_W-1:0] stall_cnt;

   // Hazard terms from the current stage contents, no latency
   always_comb begin
      lu  = bus.MemRead_EX && dep(bus.RD_EX, bus.RS_ID, bus.RT_ID, bus.UsesRt_ID);
      br2 = bus.Branch_ID && lu;
      br1 = bus.Branch_ID &&
            ((bus.RegWrite_EX && !bus.MemRead_EX &&
              dep(bus.RD_EX, bus.RS_ID, bus.RT_ID, bus.UsesRt_ID)) ||
             (bus.MemRead_MEM && dep(bus.RD_MEM, bus.RS_ID, bus.RT_ID, bus.UsesRt_ID)));
      // A MUL/DIV held in EX after its result returned must not start again
      md_hit = bus.MulDiv_EX && !started_q;
   end

   // Next state and pipeline enables; reset overrides everything with a frozen, bubbled pipe
   always_comb begin
      state_d  = state_q;
      md_cnt_d = md_cnt_q;
      err_d    = err_q;
      ctrl     = CTRL_RUN;
      case (state_q)
         ST_RUN: begin
            if (md_hit) begin
               ctrl          = CTRL_MD;
               ctrl.md_start = 1'b1;
               md_cnt_d      = '0;
               state_d       = ST_MD_WAIT;
            end else if (br2) begin
               ctrl    = CTRL_STALL;
               state_d = ST_BR_STALL2;
            end else if (lu || br1) begin
               ctrl = CTRL_STALL;
            end else if (bus.Branch_ID && bus.BranchTaken_ID) begin
               ctrl.ifid_flush = 1'b1;
            end
         end
         ST_BR_STALL2: begin
            ctrl    = CTRL_STALL;
            state_d = ST_RUN;
         end
         ST_MD_WAIT: begin
            ctrl = CTRL_MD;
            if (bus.MulDiv_Done) begin
               ctrl.exmem_bubble = 1'b0;
               md_cnt_d          = '0;
               state_d           = ST_RUN;
            end else if (md_cnt_q == TW'(MD_TIMEOUT - 1)) begin
               // Give up on the unit and let the instruction retire as if it completed
               ctrl.exmem_bubble = 1'b0;
               err_d             = 1'b1;
               md_cnt_d          = '0;
               state_d           = ST_RUN;
            end else begin
               md_cnt_d = md_cnt_q + 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase
      if (!Reset) begin
         ctrl = CTRL_RESET;
      end
      started_d = started_q;
      if (ctrl.md_start) begin
         started_d = 1'b1;
      end else if (ctrl.idex_write) begin
         started_d = 1'b0;
      end
   end

   // State registers; the started flag resets set so a MUL/DIV abandoned by reset is not reissued
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q   <= ST_RUN;
         md_cnt_q  <= '0;
         err_q     <= 1'b0;
         started_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         md_cnt_q  <= md_cnt_d;
         err_q     <= err_d;
         started_q <= started_d;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (Clk),
      .clr_n (Reset),
      .en    (!ctrl.pc_write && Reset),
      .cnt   (stall_cnt)
   );

   assign bus.PCWrite      = ctrl.pc_write;
   assign bus.IFID_Write   = ctrl.ifid_write;
   assign bus.IFID_Flush   = ctrl.ifid_flush;
   assign bus.IDEX_Write   = ctrl.idex_write;
   assign bus.IDEX_Bubble  = ctrl.idex_bubble;
   assign bus.EXMEM_Bubble = ctrl.exmem_bubble;
   assign bus.MulDiv_Start = ctrl.md_start;
   assign bus.MulDiv_Err   = err_q;
   assign bus.StallCount   = stall_cnt;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - directed scoreboard bench for hazard_stall_controller
module tb_hazard_stall_controller;

   // Expected output vector order: PCWrite IFID_Write IFID_Flush IDEX_Write IDEX_Bubble EXMEM_Bubble MulDiv_Start MulDiv_Err
   localparam logic [7:0] E_RUN    = 8'b1101_0000;
   localparam logic [7:0] E_STALL  = 8'b0001_1000;
   localparam logic [7:0] E_FLUSH  = 8'b1111_0000;
   localparam logic [7:0] E_START  = 8'b0000_0110;
   localparam logic [7:0] E_MDWAIT = 8'b0000_0100;
   localparam logic [7:0] E_MDDONE = 8'b0000_0000;
   localparam logic [7:0] E_RST    = 8'b0000_1100;

   typedef struct {
      string       tag;
      logic [7:0]  ctl;
      logic [15:0] cnt;
   } exp_t;

   logic clk;
   logic rst_n;
   logic sat_rst_n;
   int   total = 0;
   int   bad   = 0;

   exp_t        sb[$];
   logic [3:0]  sat_sb[$];
   exp_t        ec;
   logic [3:0]  sc;
   logic [15:0] exp_cnt = 16'd0;
   logic        exp_err = 1'b0;
   logic [3:0]  sexp    = 4'd0;
   logic [7:0]  obs;

   hazard_stall_controller_if #(.CNT_W(16)) hif ();
   hazard_stall_controller_if #(.CNT_W(4))  sif ();

   hazard_stall_controller #(.MD_TIMEOUT(64), .CNT_W(16)) dut (
      .Clk   (clk),
      .Reset (rst_n),
      .bus   (hif)
   );

   hazard_stall_controller #(.MD_TIMEOUT(64), .CNT_W(4)) dut_sat (
      .Clk   (clk),
      .Reset (sat_rst_n),
      .bus   (sif)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   assign obs = {hif.PCWrite, hif.IFID_Write, hif.IFID_Flush, hif.IDEX_Write,
                 hif.IDEX_Bubble, hif.EXMEM_Bubble, hif.MulDiv_Start, hif.MulDiv_Err};

   // Pop expectations on the falling edge, mid-cycle between input drive and the next rising edge
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         ec = sb.pop_front();
         total++;
         assert (obs === ec.ctl) else begin
            bad++;
            $error("FAIL %s ctl observed=%b expected=%b", ec.tag, obs, ec.ctl);
         end
         total++;
         assert (hif.StallCount === ec.cnt) else begin
            bad++;
            $error("FAIL %s StallCount observed=%0d expected=%0d", ec.tag, hif.StallCount, ec.cnt);
         end
      end
      if (sat_sb.size() != 0) begin
         sc = sat_sb.pop_front();
         total++;
         assert (sif.StallCount === sc) else begin
            bad++;
            $error("FAIL sat_cnt observed=%0d expected=%0d", sif.StallCount, sc);
         end
      end
   end

   task automatic idle();
      hif.RS_ID = 5'd0;  hif.RT_ID = 5'd0;  hif.UsesRt_ID = 1'b0;
      hif.Branch_ID = 1'b0;  hif.BranchTaken_ID = 1'b0;
      hif.RD_EX = 5'd0;  hif.RegWrite_EX = 1'b0;  hif.MemRead_EX = 1'b0;  hif.MulDiv_EX = 1'b0;
      hif.RD_MEM = 5'd0;  hif.MemRead_MEM = 1'b0;  hif.MulDiv_Done = 1'b0;
   endtask

   // Queue the expected outputs for the cycle just driven, advance the stall-count model, move one cycle
   task automatic step(input string tag, input logic [7:0] ctl);
      exp_t e;
      e.tag = tag;
      e.ctl = {ctl[7:1], exp_err};
      e.cnt = exp_cnt;
      sb.push_back(e);
      if (!rst_n) exp_cnt = 16'd0;
      else if (!ctl[7] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      sat_rst_n = 1'b0;
      idle();
      sif.RS_ID = 5'd4;  sif.RT_ID = 5'd0;  sif.UsesRt_ID = 1'b0;
      sif.Branch_ID = 1'b0;  sif.BranchTaken_ID = 1'b0;
      sif.RD_EX = 5'd4;  sif.RegWrite_EX = 1'b1;  sif.MemRead_EX = 1'b1;  sif.MulDiv_EX = 1'b0;
      sif.RD_MEM = 5'd0;  sif.MemRead_MEM = 1'b0;  sif.MulDiv_Done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      step("reset", E_RST);
      rst_n = 1'b1;
      step("idle", E_RUN);

      // Load-use on rs: one stall, then normal flow with the load in MEM
      hif.MemRead_EX = 1'b1;  hif.RD_EX = 5'd8;  hif.RS_ID = 5'd8;
      step("lu_stall", E_STALL);
      idle();  hif.RS_ID = 5'd8;  hif.MemRead_MEM = 1'b1;  hif.RD_MEM = 5'd8;
      step("lu_after", E_RUN);

      // Branch on rt of a load in EX: two stalls via BR_STALL2
      idle();  hif.MemRead_EX = 1'b1;  hif.RD_EX = 5'd9;  hif.Branch_ID = 1'b1;
      hif.RT_ID = 5'd9;  hif.UsesRt_ID = 1'b1;  hif.RS_ID = 5'd3;
      step("br2_first", E_STALL);
      hif.MemRead_EX = 1'b0;  hif.RD_EX = 5'd0;  hif.MemRead_MEM = 1'b1;  hif.RD_MEM = 5'd9;
      step("br2_second", E_STALL);
      hif.MemRead_MEM = 1'b0;  hif.RD_MEM = 5'd0;
      step("br2_release", E_RUN);

      // r0 destination and an unused rt never stall
      idle();  hif.MemRead_EX = 1'b1;  hif.RD_EX = 5'd0;  hif.Branch_ID = 1'b1;  hif.UsesRt_ID = 1'b1;
      step("br_rd_zero", E_RUN);
      idle();  hif.MemRead_EX = 1'b1;  hif.RD_EX = 5'd9;  hif.RT_ID = 5'd9;  hif.RS_ID = 5'd1;
      step("lu_rt_unused", E_RUN);

      // ALU result needed by a taken branch: stall first, flush on the following cycle
      idle();  hif.Branch_ID = 1'b1;  hif.BranchTaken_ID = 1'b1;
      hif.RegWrite_EX = 1'b1;  hif.RD_EX = 5'd5;  hif.RS_ID = 5'd5;
      step("br1_stall", E_STALL);
      hif.RegWrite_EX = 1'b0;  hif.RD_EX = 5'd0;
      step("br1_then_flush", E_FLUSH);

      // Taken branch with no dependency flushes for exactly one cycle
      idle();  hif.Branch_ID = 1'b1;  hif.BranchTaken_ID = 1'b1;  hif.RS_ID = 5'd12;
      step("flush", E_FLUSH);
      idle();
      step("flush_end", E_RUN);

      // Taken branch on a load in EX: both stall cycles win over the flush
      hif.Branch_ID = 1'b1;  hif.BranchTaken_ID = 1'b1;  hif.MemRead_EX = 1'b1;
      hif.RD_EX = 5'd7;  hif.RS_ID = 5'd7;
      step("taken_lu_stall1", E_STALL);
      hif.MemRead_EX = 1'b0;  hif.RD_EX = 5'd0;  hif.MemRead_MEM = 1'b1;  hif.RD_MEM = 5'd7;
      step("taken_lu_stall2", E_STALL);
      hif.MemRead_MEM = 1'b0;  hif.RD_MEM = 5'd0;
      step("taken_lu_flush", E_FLUSH);

      // MUL/DIV completing after five cycles; no restart while it is still in EX
      idle();  hif.MulDiv_EX = 1'b1;
      step("md_start", E_START);
      for (int i = 0; i < 4; i++) step("md_wait", E_MDWAIT);
      hif.MulDiv_Done = 1'b1;
      step("md_done", E_MDDONE);
      hif.MulDiv_Done = 1'b0;
      step("md_no_restart", E_RUN);
      hif.MulDiv_EX = 1'b0;  hif.MulDiv_Done = 1'b1;
      step("done_in_run", E_RUN);

      // MUL/DIV that never completes: timeout after 64 waits, sticky error
      idle();  hif.MulDiv_EX = 1'b1;
      step("to_start", E_START);
      for (int i = 0; i < 63; i++) step("to_wait", E_MDWAIT);
      step("to_expire", E_MDDONE);
      hif.MulDiv_EX = 1'b0;
      exp_err = 1'b1;
      step("to_err_set", E_RUN);
      step("to_err_sticky", E_RUN);

      // Reset in the middle of a MUL/DIV wait
      hif.MulDiv_EX = 1'b1;
      step("rst_md_start", E_START);
      step("rst_md_wait", E_MDWAIT);
      rst_n = 1'b0;
      step("rst_in_md", E_RST);
      rst_n = 1'b1;
      exp_err = 1'b0;
      step("rst_no_reissue", E_RUN);
      idle();
      step("rst_idle", E_RUN);

      // Narrow counter held in a permanent load-use stall reaches all-ones and stays there
      sat_rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         sat_sb.push_back(sexp);
         if (sexp != 4'hF) sexp = sexp + 4'd1;
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
